// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

    localparam int WORD_W           = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int TIMEOUT_DEF      = 64;
    localparam int CW_DEF           = 7;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_D = 2'd1,
        ARB_BUSY_I = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    function automatic logic isBusy(input arb_state_t s);
        return (s == ARB_BUSY_D) || (s == ARB_BUSY_I);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog for memory accesses: counts enabled cycles, flags the last allowed one.
module mem_arb_timer #(
    parameter int CW      = 7,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] cnt_r;
    logic          expired_r;

    // Cycle counter; expired_r is pre-decoded so it is high during the TIMEOUT-th cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else if (clear) begin
            cnt_r     <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else if (enable) begin
            cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            expired_r <= (cnt_r == CW'(TIMEOUT - 2));
        end else begin
            cnt_r     <= cnt_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store, data first
// with a starvation cap for fetch, plus a watchdog that aborts hung accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state_r, nextState_s;
    logic [SW-1:0] starveCnt_r;
    logic          memReq_r, memWe_r, ifDone_r, dDone_r, err_r;
    word_t         memAddr_r, memWdata_r, ifRdata_r, dRdata_r;
    logic          dReq_s, starveHit_s, grantD_s, grantI_s, busy_s;
    logic          okDone_s, abort_s, finish_s, expired_s;

    assign dReq_s      = d_read | d_write;
    assign starveHit_s = if_req && (starveCnt_r == SW'(STARVE_LIMIT));
    assign grantD_s    = (state_r == ARB_IDLE) && dReq_s && !starveHit_s;
    assign grantI_s    = (state_r == ARB_IDLE) && if_req && !grantD_s;
    assign busy_s      = isBusy(state_r);
    assign okDone_s    = busy_s && mem_ready;
    assign abort_s     = busy_s && !mem_ready && expired_s;
    assign finish_s    = okDone_s || abort_s;

    mem_arb_timer #(.CW(CW), .TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!busy_s),
        .enable  (busy_s),
        .expired (expired_s)
    );

    // Next-state decode: one grant per IDLE cycle, RESP always lasts one cycle.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (grantD_s) begin
                    nextState_s = ARB_BUSY_D;
                end else if (grantI_s) begin
                    nextState_s = ARB_BUSY_I;
                end else begin
                    nextState_s = ARB_IDLE;
                end
            end
            ARB_BUSY_D, ARB_BUSY_I: begin
                if (finish_s) begin
                    nextState_s = ARB_RESP;
                end else begin
                    nextState_s = state_r;
                end
            end
            ARB_RESP: nextState_s = ARB_IDLE;
            default:  nextState_s = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Consecutive data grants while fetch waits; cleared by a fetch grant or an idle fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt_r <= {SW{1'b0}};
        end else if ((state_r == ARB_IDLE) && (grantI_s || !if_req)) begin
            starveCnt_r <= {SW{1'b0}};
        end else if (grantD_s && (starveCnt_r != SW'(STARVE_LIMIT))) begin
            starveCnt_r <= starveCnt_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            starveCnt_r <= starveCnt_r;
        end
    end

    // Memory-side request: address/data latched at grant and frozen until completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= {WORD_W{1'b0}};
            memWdata_r <= {WORD_W{1'b0}};
        end else if (grantD_s) begin
            memReq_r   <= 1'b1;
            memWe_r    <= d_write;
            memAddr_r  <= d_addr;
            memWdata_r <= d_wdata;
        end else if (grantI_s) begin
            memReq_r   <= 1'b1;
            memWe_r    <= 1'b0;
            memAddr_r  <= if_addr;
            memWdata_r <= memWdata_r;
        end else if (finish_s) begin
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= memAddr_r;
            memWdata_r <= memWdata_r;
        end else begin
            memReq_r   <= memReq_r;
            memWe_r    <= memWe_r;
            memAddr_r  <= memAddr_r;
            memWdata_r <= memWdata_r;
        end
    end

    // Completion side: done pulses, read data capture (zeroed on abort), sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifDone_r  <= 1'b0;
            dDone_r   <= 1'b0;
            ifRdata_r <= {WORD_W{1'b0}};
            dRdata_r  <= {WORD_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            ifDone_r <= finish_s && (state_r == ARB_BUSY_I);
            dDone_r  <= finish_s && (state_r == ARB_BUSY_D);
            err_r    <= err_r | abort_s;
            if (finish_s && (state_r == ARB_BUSY_I)) begin
                ifRdata_r <= okDone_s ? mem_rdata : {WORD_W{1'b0}};
            end else begin
                ifRdata_r <= ifRdata_r;
            end
            if (finish_s && (state_r == ARB_BUSY_D) && !memWe_r) begin
                dRdata_r <= okDone_s ? mem_rdata : {WORD_W{1'b0}};
            end else begin
                dRdata_r <= dRdata_r;
            end
        end
    end

    assign if_rdata  = ifRdata_r;
    assign if_done   = ifDone_r;
    assign d_rdata   = dRdata_r;
    assign d_done    = dDone_r;
    assign mem_req   = memReq_r;
    assign mem_we    = memWe_r;
    assign mem_addr  = memAddr_r;
    assign mem_wdata = memWdata_r;
    assign err       = err_r;
    assign stall_f   = if_req & ~ifDone_r;
    assign stall_m   = dReq_s & ~dDone_r;

endmodule
